// File: rtl/core2wb_pkg.sv
// Shared types and default sizing for the core-to-Wishbone pipelined bridge.
package core2wb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam int DEF_PENDING = 16;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/wb_txn_tracker.sv
// Outstanding-transaction counter, response watchdog and bridge state machine.
module wb_txn_tracker
  import core2wb_pkg::*;
#(
  parameter int PENDING = DEF_PENDING,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CW = $clog2(PENDING + 1),
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          grant,
  input  logic          resp,
  output state_t        state,
  output logic [CW-1:0] count,
  output logic          timeout
);
  logic [TW-1:0] tcnt;
  logic          expire;

  // Watchdog fires on the edge that would make it reach TIMEOUT, unless a response lands.
  assign expire = (TIMEOUT != 0) && (state == ST_BUSY) && (count != '0) && !resp &&
                  (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_ABORT: begin
          tcnt <= '0;
          // One synthetic error response per cycle drains the outstanding set.
          if (count > CW'(1)) begin
            count <= count - 1'b1;
          end else begin
            count <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          if (grant && !resp)      count <= count + 1'b1;
          else if (resp && !grant) count <= count - 1'b1;

          if (count == '0 || resp)               tcnt <= '0;
          else if (state == ST_BUSY && tcnt != '1) tcnt <= tcnt + 1'b1;

          if (expire) begin
            state   <= ST_ABORT;
            timeout <= 1'b1;
          end else if (state == ST_IDLE && grant) begin
            state <= ST_BUSY;
          end else if (state == ST_BUSY && resp && !grant && count == CW'(1)) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/core2wb_pipe.sv
// Core request/response port to pipelined Wishbone bridge with abort-on-timeout.
module core2wb_pipe
  import core2wb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PENDING = DEF_PENDING,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int BE_W = DATA_W / 8,
  localparam int CW   = $clog2(PENDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  output logic              core_gnt,
  input  logic              core_we,
  input  logic [BE_W-1:0]   core_be,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [BE_W-1:0]   wb_sel,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic              wb_stall,
  output logic [CW-1:0]     pending_cnt,
  output logic              timeout_o
);
  state_t state;
  logic   room, abort, busy, resp, grant, flush;

  assign room  = pending_cnt < CW'(PENDING);
  assign abort = (state == ST_ABORT);
  assign busy  = (pending_cnt != '0);

  assign grant = core_req & ~wb_stall & room & ~abort;
  assign resp  = (wb_ack | wb_err) & wb_cyc & busy;
  assign flush = abort & busy;

  assign core_gnt = grant;
  assign wb_stb   = core_req & room & ~abort;
  assign wb_cyc   = ~abort & (core_req | busy);
  assign wb_we    = core_we;
  assign wb_adr   = core_addr;
  assign wb_dat_o = core_wdata;
  // Reads fetch the full word; byte enables only qualify writes.
  assign wb_sel   = core_we ? core_be : '1;

  assign core_rvalid = resp | flush;
  assign core_rdata  = abort ? '0 : wb_dat_i;
  assign core_err    = flush | (resp & wb_err);

  wb_txn_tracker #(
    .PENDING (PENDING),
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .grant   (grant),
    .resp    (resp),
    .state   (state),
    .count   (pending_cnt),
    .timeout (timeout_o)
  );
endmodule

// File: tb/tb_core2wb_pipe.sv
// Directed bench for core2wb_pipe: combinational vector table plus multi-cycle sequences.
module tb_core2wb_pipe;
  localparam int AW = 32, DW = 32, BW = 4, PEND = 4, TMO = 8, CW = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          core_req = 0, core_we = 0;
  logic [BW-1:0] core_be = '0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0, wb_dat_i = '0;
  logic          wb_ack = 0, wb_err = 0, wb_stall = 0;
  logic          core_gnt, core_rvalid, core_err, wb_cyc, wb_stb, wb_we, timeout_o;
  logic [DW-1:0] core_rdata, wb_dat_o;
  logic [AW-1:0] wb_adr;
  logic [BW-1:0] wb_sel;
  logic [CW-1:0] pending_cnt;

  core2wb_pipe #(.ADDR_W(AW), .DATA_W(DW), .PENDING(PEND), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall), .pending_cnt(pending_cnt), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          req, we, stall;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt, stb, cyc;
    logic [BW-1:0] sel;
  } vec_t;

  vec_t tbl[6];
  int   k;

  initial begin
    tbl[0] = '{req:0, we:0, stall:0, be:4'h0, addr:32'h0000_0000, wdata:32'h0,         gnt:0, stb:0, cyc:0, sel:4'hF};
    tbl[1] = '{req:1, we:0, stall:0, be:4'h3, addr:32'h0000_1000, wdata:32'h0,         gnt:1, stb:1, cyc:1, sel:4'hF};
    tbl[2] = '{req:1, we:1, stall:0, be:4'h3, addr:32'h0000_2004, wdata:32'hCAFE_F00D, gnt:1, stb:1, cyc:1, sel:4'h3};
    tbl[3] = '{req:1, we:1, stall:1, be:4'hA, addr:32'hFFFF_FFFC, wdata:32'h1234_5678, gnt:0, stb:1, cyc:1, sel:4'hA};
    tbl[4] = '{req:1, we:0, stall:1, be:4'h1, addr:32'h8000_0000, wdata:32'h0,         gnt:0, stb:1, cyc:1, sel:4'hF};
    tbl[5] = '{req:1, we:1, stall:0, be:4'h0, addr:32'h0000_0010, wdata:32'hA5A5_5A5A, gnt:1, stb:1, cyc:1, sel:4'h0};

    // Reset state
    @(negedge clk); #1;
    chk("rst_cnt", pending_cnt, 0); chk("rst_cyc", wb_cyc, 0); chk("rst_stb", wb_stb, 0);
    chk("rst_gnt", core_gnt, 0); chk("rst_tmo", timeout_o, 0); chk("rst_rvalid", core_rvalid, 0);
    @(negedge clk); rst_n = 1'b1;

    // Combinational vectors from IDLE; request dropped before each edge so nothing is granted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      core_req = tbl[i].req; core_we = tbl[i].we; wb_stall = tbl[i].stall;
      core_be = tbl[i].be; core_addr = tbl[i].addr; core_wdata = tbl[i].wdata;
      #1;
      chk($sformatf("tbl%0d_gnt", i), core_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_stb", i), wb_stb, tbl[i].stb);
      chk($sformatf("tbl%0d_cyc", i), wb_cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_sel", i), wb_sel, tbl[i].sel);
      chk($sformatf("tbl%0d_adr", i), wb_adr, tbl[i].addr);
      chk($sformatf("tbl%0d_dat", i), wb_dat_o, tbl[i].wdata);
      chk($sformatf("tbl%0d_we", i), wb_we, tbl[i].we);
      core_req = 0; wb_stall = 0;
    end
    chk("tbl_cnt", pending_cnt, 0);

    // Single read, ack two cycles after the grant
    @(negedge clk); core_req = 1; core_we = 0; core_addr = 32'h40; #1;
    chk("rd_gnt", core_gnt, 1);
    @(negedge clk); core_req = 0; #1;
    chk("rd_cnt1", pending_cnt, 1); chk("rd_cyc1", wb_cyc, 1); chk("rd_norv", core_rvalid, 0);
    @(negedge clk); wb_ack = 1; wb_dat_i = 32'hDEAD_BEEF; #1;
    chk("rd_rvalid", core_rvalid, 1); chk("rd_rdata", core_rdata, 32'hDEAD_BEEF); chk("rd_err", core_err, 0);
    @(negedge clk); wb_ack = 0; #1;
    chk("rd_cnt0", pending_cnt, 0); chk("rd_cyc0", wb_cyc, 0); chk("rd_rv0", core_rvalid, 0);

    // Six back-to-back requests, no ack, only PEND granted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); core_req = 1; core_addr = 32'(i * 4); #1;
      chk($sformatf("b2b%0d_gnt", i), core_gnt, (i < PEND) ? 1 : 0);
    end
    @(negedge clk); core_req = 0; #1;
    chk("b2b_cnt", pending_cnt, PEND); chk("b2b_cyc", wb_cyc, 1);
    @(negedge clk); wb_ack = 1;
    @(negedge clk); wb_ack = 1; #1;
    chk("b2b_cnt3", pending_cnt, 3);
    // Grant and response in the same cycle with two outstanding
    @(negedge clk); core_req = 1; wb_ack = 1; #1;
    chk("both_cnt_pre", pending_cnt, 2); chk("both_gnt", core_gnt, 1); chk("both_rv", core_rvalid, 1);
    @(negedge clk); core_req = 0; wb_ack = 0; #1;
    chk("both_cnt", pending_cnt, 2);
    @(negedge clk); wb_ack = 1;
    @(negedge clk); wb_ack = 1;
    @(negedge clk); wb_ack = 0; #1;
    chk("drain_cnt", pending_cnt, 0); chk("drain_cyc", wb_cyc, 0);

    // Timeout with three outstanding: eight BUSY cycles, then pulse and flush
    @(negedge clk); core_req = 1; core_we = 0;
    repeat (2) @(negedge clk);
    @(negedge clk); core_req = 0; k = 3;
    while (!timeout_o && k < 40) begin
      @(negedge clk); k++;
    end
    chk("tmo_cycle", k, 9);
    core_req = 1; wb_ack = 1; wb_dat_i = 32'h1234_5678; #1;
    chk("ab_tmo", timeout_o, 1); chk("ab_cyc", wb_cyc, 0); chk("ab_stb", wb_stb, 0);
    chk("ab_gnt", core_gnt, 0); chk("ab_rv0", core_rvalid, 1); chk("ab_err0", core_err, 1);
    chk("ab_rdata", core_rdata, 0); chk("ab_cnt3", pending_cnt, 3);
    @(negedge clk); core_req = 0; #1;
    chk("ab_tmo_pulse", timeout_o, 0); chk("ab_cnt2", pending_cnt, 2);
    chk("ab_rv1", core_rvalid, 1); chk("ab_err1", core_err, 1);
    @(negedge clk); wb_ack = 0; #1;
    chk("ab_cnt1", pending_cnt, 1); chk("ab_rv2", core_rvalid, 1); chk("ab_err2", core_err, 1);
    @(negedge clk); #1;
    chk("ab_cnt0", pending_cnt, 0); chk("ab_rv_end", core_rvalid, 0); chk("ab_cyc_end", wb_cyc, 0);
    core_req = 1; #1;
    chk("ab_idle_gnt", core_gnt, 1);
    core_req = 0;

    // Stray ack with nothing outstanding
    @(negedge clk); wb_ack = 1; #1;
    chk("stray_rv", core_rvalid, 0);
    @(negedge clk); wb_ack = 0; #1;
    chk("stray_cnt", pending_cnt, 0);

    // Reset with transactions outstanding discards them silently
    for (int i = 0; i < PEND; i++) begin
      @(negedge clk); core_req = 1;
    end
    @(negedge clk); core_req = 0; #1;
    chk("mrst_pre", pending_cnt, PEND);
    rst_n = 0; #1;
    chk("mrst_cnt", pending_cnt, 0); chk("mrst_cyc", wb_cyc, 0); chk("mrst_rv", core_rvalid, 0);
    @(negedge clk); wb_ack = 1; #1;
    chk("mrst_ack_rv", core_rvalid, 0);
    @(negedge clk); wb_ack = 0; rst_n = 1;
    @(negedge clk); #1;
    chk("mrst_post_cnt", pending_cnt, 0); chk("mrst_post_cyc", wb_cyc, 0); chk("mrst_post_rv", core_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
